// File: rtl/kpd_seq_pkg.sv
// Shared definitions for the keypad APB sequencer: register map, bit positions, state encodings.
package kpd_seq_pkg;

  localparam logic [7:0] ADDR_CLK_DIV  = 8'h00;
  localparam logic [7:0] ADDR_DEBOUNCE = 8'h04;
  localparam logic [7:0] ADDR_TIMEOUT  = 8'h08;
  localparam logic [7:0] ADDR_STATUS   = 8'h0C;
  localparam logic [7:0] ADDR_RESERVED = 8'h10;
  localparam logic [7:0] ADDR_KEY_POS  = 8'h14;
  localparam logic [7:0] ADDR_KEY_ASC  = 8'h18;
  localparam logic [7:0] ADDR_CONTROL  = 8'h1C;

  localparam int CTRL_IRQ_CLR_BIT   = 0;
  localparam int CTRL_POP_BIT       = 1;
  localparam int STAT_POS_EMPTY_BIT = 0;

  typedef enum logic [3:0] {
    CFG_DIV, CFG_DEB, CFG_TMO, WAIT_IRQ, RD_STAT, RD_POS,
    RD_ASC, PUSH, POP, SETTLE, CLR_IRQ
  } seq_state_t;

  typedef enum logic [1:0] {XF_IDLE, XF_SETUP, XF_ACCESS, XF_RDCAP} xfer_state_t;

  function automatic logic [31:0] ctrl_word(input int bitpos);
    return 32'h1 << bitpos;
  endfunction

endpackage

// File: rtl/kpd_apb_xfer.sv
// Single-transfer APB master: one request becomes SETUP + ACCESS (+ read capture), then a done pulse.
module kpd_apb_xfer
  import kpd_seq_pkg::*;
(
  input  logic        pclk,
  input  logic        presetn,
  input  logic        i_req,
  input  logic [7:0]  i_addr,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_psel,
  output logic        o_penable,
  output logic [7:0]  o_paddr,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready
);

  xfer_state_t r_state, w_nxt;
  logic        r_done, r_write;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata, r_rdata;
  logic        w_start;

  // A request held over its own done cycle must not launch a second transfer.
  assign w_start = (r_state == XF_IDLE) && i_req && !r_done;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      XF_IDLE:   if (w_start) w_nxt = XF_SETUP;
      XF_SETUP:  w_nxt = XF_ACCESS;
      XF_ACCESS: if (i_pready) w_nxt = r_write ? XF_IDLE : XF_RDCAP;
      XF_RDCAP:  w_nxt = XF_IDLE;
      default:   w_nxt = XF_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= XF_IDLE;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= ((r_state == XF_ACCESS) && i_pready && r_write) || (r_state == XF_RDCAP);
      // Slave presents read data one cycle after the completing ACCESS cycle.
      if (r_state == XF_RDCAP) r_rdata <= i_prdata;
      if (w_start) begin
        r_addr  <= i_addr;
        r_write <= i_write;
        r_wdata <= i_write ? i_wdata : '0;
      end
    end
  end

  assign o_psel    = (r_state == XF_SETUP) || (r_state == XF_ACCESS);
  assign o_penable = (r_state == XF_ACCESS);
  assign o_paddr   = r_addr;
  assign o_pwrite  = r_write;
  assign o_pwdata  = r_wdata;
  assign o_done    = r_done;
  assign o_rdata   = r_rdata;

endmodule

// File: rtl/kpd_apb_sequencer.sv
// Keypad controller sequencer: configures the keypad over APB, then drains its FIFO on each interrupt.
// Optional KPD_SEQ_KEYCOUNT_EN adds a 16-bit wrapping count of delivered key records.
module kpd_apb_sequencer
  import kpd_seq_pkg::*;
#(
  parameter logic [19:0] CLK_DIV_INIT  = 20'd50000,
  parameter logic [7:0]  DEBOUNCE_INIT = 8'd20,
  parameter logic [3:0]  TIMEOUT_INIT  = 4'd8,
  parameter int          SETTLE_CYCLES = 8
)(
  input  logic        pclk,
  input  logic        presetn,
  output logic        psel,
  output logic        penable,
  output logic [7:0]  paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        irq_i,
  output logic        cfg_done_o,
  output logic        key_valid_o,
  input  logic        key_ready_i,
  output logic [5:0]  key_pos_o,
  output logic [7:0]  key_ascii_o
`ifdef KPD_SEQ_KEYCOUNT_EN
  ,
  output logic [15:0] key_count_o
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  seq_state_t  r_state, w_nxt;
  logic        w_req, w_write, w_done;
  logic [7:0]  w_addr;
  logic [31:0] w_wdata, w_rdata;
  logic        r_cfg_done;
  logic [5:0]  r_key_pos;
  logic [7:0]  r_key_ascii;
  logic [SW-1:0] r_settle;
  logic        w_unused_rdata;

  assign w_unused_rdata = |w_rdata[31:8];

  kpd_apb_xfer u_xfer (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_req     (w_req),
    .i_addr    (w_addr),
    .i_write   (w_write),
    .i_wdata   (w_wdata),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .o_psel    (psel),
    .o_penable (penable),
    .o_paddr   (paddr),
    .o_pwrite  (pwrite),
    .o_pwdata  (pwdata),
    .i_prdata  (prdata),
    .i_pready  (pready)
  );

  always_comb begin
    w_nxt   = r_state;
    w_req   = 1'b0;
    w_addr  = '0;
    w_write = 1'b0;
    w_wdata = '0;
    case (r_state)
      CFG_DIV: begin
        w_req = 1'b1; w_addr = ADDR_CLK_DIV; w_write = 1'b1; w_wdata = 32'(CLK_DIV_INIT);
        if (w_done) w_nxt = CFG_DEB;
      end
      CFG_DEB: begin
        w_req = 1'b1; w_addr = ADDR_DEBOUNCE; w_write = 1'b1; w_wdata = 32'(DEBOUNCE_INIT);
        if (w_done) w_nxt = CFG_TMO;
      end
      CFG_TMO: begin
        w_req = 1'b1; w_addr = ADDR_TIMEOUT; w_write = 1'b1; w_wdata = 32'(TIMEOUT_INIT);
        if (w_done) w_nxt = WAIT_IRQ;
      end
      WAIT_IRQ: if (irq_i) w_nxt = RD_STAT;
      RD_STAT: begin
        w_req = 1'b1; w_addr = ADDR_STATUS;
        if (w_done) w_nxt = w_rdata[STAT_POS_EMPTY_BIT] ? CLR_IRQ : RD_POS;
      end
      RD_POS: begin
        w_req = 1'b1; w_addr = ADDR_KEY_POS;
        if (w_done) w_nxt = RD_ASC;
      end
      RD_ASC: begin
        w_req = 1'b1; w_addr = ADDR_KEY_ASC;
        if (w_done) w_nxt = PUSH;
      end
      PUSH: if (key_ready_i) w_nxt = POP;
      POP: begin
        w_req = 1'b1; w_addr = ADDR_CONTROL; w_write = 1'b1; w_wdata = ctrl_word(CTRL_POP_BIT);
        if (w_done) w_nxt = SETTLE;
      end
      // Give the keypad time to update its FIFO status after a pop.
      SETTLE: if (r_settle == SW'(SETTLE_CYCLES - 1)) w_nxt = RD_STAT;
      CLR_IRQ: begin
        w_req = 1'b1; w_addr = ADDR_CONTROL; w_write = 1'b1; w_wdata = ctrl_word(CTRL_IRQ_CLR_BIT);
        if (w_done) w_nxt = WAIT_IRQ;
      end
      default: w_nxt = CFG_DIV;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= CFG_DIV;
      r_cfg_done  <= 1'b0;
      r_key_pos   <= '0;
      r_key_ascii <= '0;
      r_settle    <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == CFG_TMO && w_done) r_cfg_done <= 1'b1;
      if (r_state == RD_POS && w_done) r_key_pos <= w_rdata[5:0];
      if (r_state == RD_ASC && w_done) r_key_ascii <= w_rdata[7:0];
      r_settle <= (r_state == SETTLE) ? r_settle + SW'(1) : '0;
    end
  end

  assign cfg_done_o  = r_cfg_done;
  assign key_valid_o = (r_state == PUSH);
  assign key_pos_o   = r_key_pos;
  assign key_ascii_o = r_key_ascii;

`ifdef KPD_SEQ_KEYCOUNT_EN
  logic [15:0] r_key_count;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_key_count <= '0;
    else if (r_state == PUSH && key_ready_i) r_key_count <= r_key_count + 16'd1;
  end

  assign key_count_o = r_key_count;
`endif

endmodule

// File: tb/tb_kpd_apb_sequencer.sv
// Randomized bench for kpd_apb_sequencer: keypad APB slave model, expected-transfer and key-record scoreboards.
module tb_kpd_apb_sequencer;

  localparam int SETTLE = 8;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        irq_i;
  logic        cfg_done_o, key_valid_o;
  logic        key_ready_i = 1'b0;
  logic [5:0]  key_pos_o;
  logic [7:0]  key_ascii_o;
`ifdef KPD_SEQ_KEYCOUNT_EN
  logic [15:0] key_count_o;
`endif

  always #5 pclk = ~pclk;

  kpd_apb_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .irq_i(irq_i),
    .cfg_done_o(cfg_done_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i),
    .key_pos_o(key_pos_o), .key_ascii_o(key_ascii_o)
`ifdef KPD_SEQ_KEYCOUNT_EN
    , .key_count_o(key_count_o)
`endif
  );

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Keypad FIFO contents (test pushes, slave pops)
  logic [5:0]  kpos [256];
  logic [7:0]  kasc [256];
  logic [7:0]  kwr = 0, krd = 0;
  // Expected APB transfers
  logic        ex_w [1024];
  logic [7:0]  ex_a [1024];
  logic [31:0] ex_d [1024];
  logic [9:0]  ewr = 0, erd = 0;
  // Expected key records
  logic [5:0]  rp [256];
  logic [7:0]  ra [256];
  logic [7:0]  rwr = 0, rrd = 0;
  int irq_set = 0, irq_clr = 0;
  assign irq_i = (irq_set != irq_clr);

  int rdy_pct = 100;
  bit rand_stall = 0;
  int force_stall_n = -1;
  logic [7:0] force_stall_a = 8'h00;

  task automatic exp_x(input logic w, input logic [7:0] a, input logic [31:0] d);
    ex_w[ewr] = w; ex_a[ewr] = a; ex_d[ewr] = d;
    ewr = ewr + 10'd1;
  endtask

  task automatic push_cfg();
    exp_x(1'b1, 8'h00, 32'd50000);
    exp_x(1'b1, 8'h04, 32'd20);
    exp_x(1'b1, 8'h08, 32'd8);
  endtask

  task automatic add_key(input logic [5:0] p, input logic [7:0] a);
    kpos[kwr] = p; kasc[kwr] = a; kwr = kwr + 8'd1;
    rp[rwr] = p;   ra[rwr] = a;   rwr = rwr + 8'd1;
  endtask

  // Each queued key: status, position, ascii, pop; then a final empty status and irq clear.
  task automatic fire(input int nkeys);
    for (int i = 0; i < nkeys; i++) begin
      exp_x(1'b0, 8'h0C, 32'h0);
      exp_x(1'b0, 8'h14, 32'h0);
      exp_x(1'b0, 8'h18, 32'h0);
      exp_x(1'b1, 8'h1C, 32'h2);
    end
    exp_x(1'b0, 8'h0C, 32'h0);
    exp_x(1'b1, 8'h1C, 32'h1);
    irq_set++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((ewr != erd || rwr != rrd || irq_i) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    repeat (4) @(negedge pclk);
    chk("drain_done", (ewr != erd) || (rwr != rrd) || irq_i, 0);
  endtask

  initial forever begin
    @(posedge pclk);
    #2;
    key_ready_i = ($urandom_range(0, 99) < rdy_pct);
  end

  // Slave + monitor, evaluated at the falling edge
  int cyc = 0, s_cyc = 0, stall = 0, s_stall = 0, proto_err = 0, pop_cyc = -1, len04 = 0;
  int hold = 0, last_hold = 0, hs_since_rst = 0;
  bit in_x = 0, unstable = 0, rd_pend = 0, vld_prev = 0, v_bad = 0, v_apb = 0;
  logic [7:0]  s_a;
  logic        s_w;
  logic [31:0] s_d, rd_val;
  logic [5:0]  v_p;
  logic [7:0]  v_a;

  initial forever begin
    @(negedge pclk);
    cyc++;
    if (!presetn) begin
      in_x = 0; rd_pend = 0; vld_prev = 0; pop_cyc = -1; hs_since_rst = 0;
      erd = ewr; rrd = rwr; krd = kwr; irq_clr = irq_set;
      pready = 1'b0;
      prdata = $urandom;
    end else begin
      prdata = rd_pend ? rd_val : $urandom;
      rd_pend = 0;
      if (penable && !psel) proto_err++;
      if (psel && !penable) begin
        if (in_x) proto_err++;
        in_x = 1; s_a = paddr; s_w = pwrite; s_d = pwdata; s_cyc = cyc; unstable = 0;
        stall = (force_stall_n >= 0 && paddr == force_stall_a) ? force_stall_n :
                (rand_stall ? int'($urandom_range(0, 3)) : 0);
        s_stall = stall;
        pready = 1'($urandom_range(0, 1));
        if (paddr == 8'h0C && pop_cyc >= 0) begin
          chk("settle_gap", (cyc - pop_cyc >= SETTLE + 1) && (cyc - pop_cyc <= SETTLE + 5), 1);
          pop_cyc = -1;
        end
      end else if (psel && penable) begin
        if (!in_x) proto_err++;
        if (paddr !== s_a || pwrite !== s_w || pwdata !== s_d) unstable = 1;
        pready = (stall == 0);
        if (stall > 0) stall--;
        if (pready) begin
          in_x = 0;
          chk("xfer_len", cyc - s_cyc + 1, 2 + s_stall);
          chk("xfer_expected", erd != ewr, 1);
          if (erd != ewr) begin
            chk("xfer_addr", s_a, ex_a[erd]);
            chk("xfer_dir", s_w, ex_w[erd]);
            chk("xfer_wdata", s_d, ex_w[erd] ? ex_d[erd] : 32'h0);
            chk("xfer_stable", unstable, 0);
            erd = erd + 10'd1;
          end
          if (s_w && (s_a == 8'h00 || s_a == 8'h04)) chk("cfg_done_early", cfg_done_o, 0);
          if (s_a == 8'h04) len04 = cyc - s_cyc + 1;
          if (s_w && s_a == 8'h1C) begin
            if (s_d[1]) begin
              if (kwr != krd) krd = krd + 8'd1;
              pop_cyc = cyc;
            end
            if (s_d[0]) irq_clr = irq_set;
          end
          if (!s_w) begin
            rd_pend = 1;
            rd_val = $urandom;
            if (s_a == 8'h0C) rd_val[0] = (kwr == krd);
            if (s_a == 8'h14) rd_val[5:0] = kpos[krd];
            if (s_a == 8'h18) rd_val[7:0] = kasc[krd];
          end
        end
      end else begin
        if (in_x) begin proto_err++; in_x = 0; end
        pready = 1'($urandom_range(0, 1));
      end

      if (key_valid_o) begin
        if (!vld_prev) begin
          chk("rec_expected", rrd != rwr, 1);
          chk("key_pos", key_pos_o, rp[rrd]);
          chk("key_ascii", key_ascii_o, ra[rrd]);
          v_p = key_pos_o; v_a = key_ascii_o; hold = 0; v_bad = 0; v_apb = 0;
        end
        hold++;
        if (key_pos_o !== v_p || key_ascii_o !== v_a) v_bad = 1;
        if (psel) v_apb = 1;
        if (key_ready_i) begin
          chk("rec_stable", v_bad, 0);
          chk("push_no_apb", v_apb, 0);
          last_hold = hold;
          rrd = rrd + 8'd1;
          hs_since_rst++;
          vld_prev = 0;
        end else begin
          vld_prev = 1;
        end
      end else begin
        vld_prev = 0;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge pclk);
    chk("rst_outs", {psel, penable, pwrite, paddr, pwdata, cfg_done_o, key_valid_o, key_pos_o, key_ascii_o}, 0);
    push_cfg();
    presetn = 1'b1;
    wait_idle(200);
    chk("cfg_done", cfg_done_o, 1);

    add_key(6'h15, 8'h35);
    fire(1);
    wait_idle(400);

    fire(0);
    wait_idle(200);

    rdy_pct = 0;
    add_key(6'($urandom), 8'($urandom));
    add_key(6'($urandom), 8'($urandom));
    fire(2);
    n = 0;
    while (!(key_valid_o && hold >= 10) && n < 400) begin @(negedge pclk); n++; end
    rdy_pct = 100;
    n = 0;
    while (key_valid_o && n < 50) begin @(negedge pclk); n++; end
    chk("ready_hold", last_hold >= 10, 1);
    wait_idle(400);

    rand_stall = 1;
    rdy_pct = 60;
    for (int it = 0; it < 20; it++) begin
      int k;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) add_key(6'($urandom), 8'($urandom));
      fire(k);
      wait_idle(2000);
    end

    rand_stall = 0;
    rdy_pct = 100;
    add_key(6'($urandom), 8'($urandom));
    fire(1);
    n = 0;
    while (!(psel && penable && paddr == 8'h14) && n < 500) begin @(negedge pclk); n++; end
    chk("saw_rd_pos", psel && penable && paddr == 8'h14, 1);
    #1 presetn = 1'b0;
    #1 chk("rst_async", {psel, penable, pwrite, paddr, pwdata, cfg_done_o, key_valid_o, key_pos_o, key_ascii_o}, 0);
    @(negedge pclk);
    chk("rst_hold", {psel, penable, pwrite, paddr, pwdata, cfg_done_o, key_valid_o, key_pos_o, key_ascii_o}, 0);
    repeat (2) @(negedge pclk);
    force_stall_a = 8'h04;
    force_stall_n = 3;
    push_cfg();
    presetn = 1'b1;
    wait_idle(300);
    chk("deb_stall_len", len04, 5);
    chk("cfg_done2", cfg_done_o, 1);
    force_stall_n = -1;

    rand_stall = 1;
    rdy_pct = 70;
    for (int it = 0; it < 3; it++) begin
      add_key(6'($urandom), 8'($urandom));
      fire(1);
      wait_idle(1000);
    end
`ifdef KPD_SEQ_KEYCOUNT_EN
    chk("key_count", key_count_o, 16'(hs_since_rst));
`endif
    chk("proto_errs", proto_err, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
